// File: rtl/alu_pkg.sv
// Shared definitions for the ALU register sequencer: opcodes, FSM states, flag-update selection.
// Latency: n/a (package).
// Backpressure: n/a (package).
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_COMP = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Bit n set means opcode n refreshes C, AC and S (arithmetic ops only).
    localparam logic [7:0] FULL_FLAG_OPS = 8'b0000_0011;

    function automatic logic updates_all_flags(input logic [2:0] op);
        return FULL_FLAG_OPS[op];
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x 8-bit register file: one write port, two operand read ports, one host read port.
// Latency: reads are combinational, write lands on the next rising edge.
// Backpressure: none; the owner arbitrates the single write port.
module alu_regfile #(
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    input  logic [AW-1:0] raddr_h,
    output logic [7:0]    rdata_a,
    output logic [7:0]    rdata_b,
    output logic [7:0]    rdata_h
);

    logic [7:0] regs [NREGS];

    // Storage: cleared by reset, single write per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_h = regs[raddr_h];

endmodule

// File: rtl/alu_reg_sequencer.sv
// Sequences one command at a time: capture operands, drive the external ALU, write back result and flags.
// Latency: accept at edge T, writeback at T+1, done pulse in the cycle after; one command per 3 cycles.
// Backpressure: cmd_ready only in IDLE and only when no host write is requested.
module alu_reg_sequencer
    import alu_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_srca,
    input  logic [AW-1:0] cmd_srcb,
    input  logic [AW-1:0] cmd_dst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_opcode,
    input  logic [7:0]    alu_res,
    input  logic          alu_c,
    input  logic          alu_ac,
    input  logic          alu_s,
    input  logic          alu_z,
    output logic          flag_c,
    output logic          flag_ac,
    output logic          flag_s,
    output logic          flag_z,
    output logic          done
);

    state_t        state, state_nxt;
    logic [7:0]    op_a, op_b;
    logic [2:0]    op_code;
    logic [AW-1:0] dst;
    logic          accept;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [7:0]    rf_wdata;
    logic [7:0]    rf_rdata_a, rf_rdata_b;

    alu_regfile #(.NREGS(NREGS), .AW(AW)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (cmd_srca),
        .raddr_b (cmd_srcb),
        .raddr_h (rd_addr),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .rdata_h (rd_data)
    );

    // Next state, handshake and the write-port mux (host write in IDLE, writeback in EXEC).
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = dst;
        rf_wdata  = alu_res;
        case (state)
            ST_IDLE: begin
                cmd_ready = !wr_en;
                if (wr_en) begin
                    rf_we    = 1'b1;
                    rf_waddr = wr_addr;
                    rf_wdata = wr_data;
                end else if (cmd_valid) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rf_we     = 1'b1;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = cmd_valid && cmd_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands are sampled at accept so a destination aliasing a source is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a    <= 8'h00;
            op_b    <= 8'h00;
            op_code <= 3'b000;
            dst     <= '0;
        end else if (accept) begin
            op_a    <= rf_rdata_a;
            op_b    <= rf_rdata_b;
            op_code <= cmd_op;
            dst     <= cmd_dst;
        end
    end

    // Flags latch with the writeback; only arithmetic ops refresh C, AC and S.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c  <= 1'b0;
            flag_ac <= 1'b0;
            flag_s  <= 1'b0;
            flag_z  <= 1'b0;
        end else if (state == ST_EXEC) begin
            flag_z <= alu_z;
            if (updates_all_flags(op_code)) begin
                flag_c  <= alu_c;
                flag_ac <= alu_ac;
                flag_s  <= alu_s;
            end
        end
    end

    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_opcode = op_code;

endmodule
